// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch geometry, fetch-queue entry type and first-bundle lane mask helper.
package fetch_pkg;
  localparam int LANES = 4;
  localparam int INST_W = 32;
  localparam int BUNDLE_W = 128;
  localparam int BUNDLE_BYTES = 16;
  typedef struct packed {
    logic [BUNDLE_W-1:0] inst;
    logic [31:0] pc;
    logic [LANES-1:0] mask;
  } fetch_entry_t;
  // Lanes below the entry point of a redirect/reset target are not executed.
  function automatic logic [LANES-1:0] first_mask(input logic [1:0] lane);
    return {LANES{1'b1}} << lane;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch entries with flush; pointers wrap modulo DEPTH.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
  // The upstream credit rule must never let a push land on a full queue.
  assert property (@(posedge i_clk) disable iff (!i_resetn)
    !(push && !flush && !do_pop && count == CW'(DEPTH)));
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC, bundle read requests, fetch queue and redirect flush.
// Optional FETCH_PERF_EN adds saturating bundle/redirect/stall counters.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  output logic                o_imem_valid,
  output logic [ADDR_W-1:0]   o_imem_raddr,
  input  logic                i_imem_ready,
  input  logic [BUNDLE_W-1:0] i_imem_rinst,
  input  logic                i_redirect_valid,
  input  logic [31:0]         i_redirect_pc,
  output logic                o_fq_valid,
  output logic [BUNDLE_W-1:0] o_fq_inst,
  output logic [31:0]         o_fq_pc,
  output logic [LANES-1:0]    o_fq_mask,
  input  logic                i_fq_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         o_perf_bundles,
  output logic [31:0]         o_perf_redirects,
  output logic [31:0]         o_perf_stall_cycles
`endif
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  logic [31:0] fpc, inflight_pc;
  logic [LANES-1:0] cur_mask, inflight_mask;
  logic inflight_v, issue, push, pop, no_credit;
  logic [CW-1:0] count;
  fetch_entry_t head;
  // Queued plus in-flight bundles may never exceed the queue depth.
  assign no_credit = 32'(count) + 32'(inflight_v) >= 32'(FQ_DEPTH);
  assign issue = i_resetn && !no_credit && !i_redirect_valid;
  assign o_imem_valid = issue || inflight_v;
  assign o_imem_raddr = fpc[ADDR_W+3:4];
  assign push = inflight_v && i_imem_ready && !i_redirect_valid;
  assign pop = o_fq_valid && i_fq_ready;
  assign o_fq_valid = count != '0;
  assign o_fq_inst = head.inst;
  assign o_fq_pc = head.pc;
  assign o_fq_mask = head.mask;
  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .i_clk   (i_clk),
    .i_resetn(i_resetn),
    .flush   (i_redirect_valid),
    .push    (push),
    .pop     (pop),
    .din     ('{inst: i_imem_rinst, pc: inflight_pc, mask: inflight_mask}),
    .head    (head),
    .count   (count)
  );
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      fpc <= RESET_PC & ~32'h3;
      cur_mask <= first_mask(RESET_PC[3:2]);
      inflight_v <= 1'b0;
      inflight_pc <= '0;
      inflight_mask <= '0;
    end else if (i_redirect_valid) begin
      fpc <= i_redirect_pc & ~32'h3;
      cur_mask <= first_mask(i_redirect_pc[3:2]);
      inflight_v <= 1'b0;
    end else begin
      inflight_v <= issue;
      if (issue) begin
        inflight_pc <= fpc & ~32'hF;
        inflight_mask <= cur_mask;
        fpc <= (fpc & ~32'hF) + 32'(BUNDLE_BYTES);
        cur_mask <= {LANES{1'b1}};
      end
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      o_perf_bundles <= '0;
      o_perf_redirects <= '0;
      o_perf_stall_cycles <= '0;
    end else begin
      if (push && o_perf_bundles != '1) o_perf_bundles <= o_perf_bundles + 32'd1;
      if (i_redirect_valid && o_perf_redirects != '1) o_perf_redirects <= o_perf_redirects + 32'd1;
      if (no_credit && o_perf_stall_cycles != '1) o_perf_stall_cycles <= o_perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed bench with a one-cycle-latency memory holding word value = word index.
module tb_inst_fetch_unit;
  logic clk = 1'b0;
  logic i_resetn, o_imem_valid, i_imem_ready, i_redirect_valid, o_fq_valid, i_fq_ready;
  logic [9:0] o_imem_raddr;
  logic [127:0] i_imem_rinst, o_fq_inst;
  logic [31:0] i_redirect_pc, o_fq_pc;
  logic [3:0] o_fq_mask;
`ifdef FETCH_PERF_EN
  logic [31:0] o_perf_bundles, o_perf_redirects, o_perf_stall_cycles;
`endif
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .i_clk(clk), .i_resetn(i_resetn),
    .o_imem_valid(o_imem_valid), .o_imem_raddr(o_imem_raddr),
    .i_imem_ready(i_imem_ready), .i_imem_rinst(i_imem_rinst),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_fq_valid(o_fq_valid), .o_fq_inst(o_fq_inst), .o_fq_pc(o_fq_pc),
    .o_fq_mask(o_fq_mask), .i_fq_ready(i_fq_ready)
`ifdef FETCH_PERF_EN
    , .o_perf_bundles(o_perf_bundles), .o_perf_redirects(o_perf_redirects),
    .o_perf_stall_cycles(o_perf_stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] bundle(input logic [9:0] a);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[32*k +: 32] = 32'(a) * 32'd4 + 32'(k);
    return b;
  endfunction

  // Memory answers the request seen in the previous cycle, one cycle later.
  task automatic tick();
    logic v;
    logic [9:0] a;
    @(negedge clk);
    v = o_imem_valid;
    a = o_imem_raddr;
    @(posedge clk);
    #1;
    i_imem_ready = v;
    i_imem_rinst = bundle(a);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [3:0] mask, input logic [31:0] lane0);
    check({tag, "_valid"}, 128'(o_fq_valid), 128'(1));
    check({tag, "_pc"}, 128'(o_fq_pc), 128'(pc));
    check({tag, "_mask"}, 128'(o_fq_mask), 128'(mask));
    check({tag, "_lane0"}, 128'(o_fq_inst[31:0]), 128'(lane0));
  endtask

  initial begin
    i_resetn = 1'b0;
    i_fq_ready = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc = '0;
    i_imem_ready = 1'b0;
    i_imem_rinst = '0;
    tick();
    tick();
    check("rst_fq_valid", 128'(o_fq_valid), 128'(0));
    check("rst_imem_valid", 128'(o_imem_valid), 128'(0));
    check("rst_fq_pc", 128'(o_fq_pc), 128'(0));
    check("rst_fq_mask", 128'(o_fq_mask), 128'(0));
    check("rst_fq_inst", o_fq_inst, 128'(0));
    // Streaming with decode always ready.
    i_resetn = 1'b1;
    #1;
    check("c0_imem_valid", 128'(o_imem_valid), 128'(1));
    check("c0_raddr", 128'(o_imem_raddr), 128'(0));
    tick();
    check("c1_fq_valid", 128'(o_fq_valid), 128'(0));
    tick();
    check_head("s0", 32'h00, 4'hF, 32'd0);
    tick();
    check_head("s1", 32'h10, 4'hF, 32'd4);
    tick();
    check_head("s2", 32'h20, 4'hF, 32'd8);
    // Mid-stream reset, then decode stalled from reset.
    i_resetn = 1'b0;
    i_fq_ready = 1'b0;
    tick();
    check("mrst_fq_valid", 128'(o_fq_valid), 128'(0));
    check("mrst_raddr", 128'(o_imem_raddr), 128'(0));
    check("mrst_imem_valid", 128'(o_imem_valid), 128'(0));
    i_resetn = 1'b1;
    repeat (4) tick();
    #1;
    check("drain_valid", 128'(o_imem_valid), 128'(1));
    check("drain_raddr", 128'(o_imem_raddr), 128'(4));
    tick();
    check("full_imem_valid", 128'(o_imem_valid), 128'(0));
    check_head("full0", 32'h00, 4'hF, 32'd0);
    tick();
    check("full_hold_imem_valid", 128'(o_imem_valid), 128'(0));
    check("full_hold_pc", 128'(o_fq_pc), 128'(0));
    i_fq_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_head($sformatf("resume%0d", i), 32'(i * 16), 4'hF, 32'(i * 4));
    end
    // Refill to full, then redirect with a pop in the same cycle.
    i_fq_ready = 1'b0;
    tick();
    tick();
    check("refull_imem_valid", 128'(o_imem_valid), 128'(0));
    i_fq_ready = 1'b1;
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h0000_0128;
    #1;
    check("redir_no_issue", 128'(o_imem_valid), 128'(0));
    tick();
    i_redirect_valid = 1'b0;
    check("redir_flush", 128'(o_fq_valid), 128'(0));
    #1;
    check("redir_raddr", 128'(o_imem_raddr), 128'(10'h12));
    check("redir_issue", 128'(o_imem_valid), 128'(1));
    tick();
    check("redir_c1_empty", 128'(o_fq_valid), 128'(0));
    tick();
    check_head("redir_b0", 32'h120, 4'b1100, 32'h48);
    tick();
    check_head("redir_b1", 32'h130, 4'hF, 32'h4C);
    // Redirect while a response is arriving: stale data must be dropped.
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h0000_0204;
    tick();
    i_redirect_valid = 1'b0;
    check("stale_c1_empty", 128'(o_fq_valid), 128'(0));
    tick();
    check("stale_c2_empty", 128'(o_fq_valid), 128'(0));
    tick();
    check_head("stale_b0", 32'h200, 4'b1110, 32'h80);
    tick();
    check_head("stale_b1", 32'h210, 4'hF, 32'h84);
    // Bundle-address wrap at the top of the 10-bit space.
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h0000_3FF0;
    tick();
    i_redirect_valid = 1'b0;
    #1;
    check("wrap_raddr_top", 128'(o_imem_raddr), 128'(10'h3FF));
    tick();
    check("wrap_raddr_zero", 128'(o_imem_raddr), 128'(0));
    tick();
    check_head("wrap_b0", 32'h3FF0, 4'hF, 32'hFFC);
    tick();
    check_head("wrap_b1", 32'h4000, 4'hF, 32'h0);
    // One-cycle reset mid-stream.
    i_resetn = 1'b0;
    tick();
    check("rst2_fq_valid", 128'(o_fq_valid), 128'(0));
    check("rst2_raddr", 128'(o_imem_raddr), 128'(0));
    check("rst2_imem_valid", 128'(o_imem_valid), 128'(0));
`ifdef FETCH_PERF_EN
    check("rst2_perf_bundles", 128'(o_perf_bundles), 128'(0));
    check("rst2_perf_redirects", 128'(o_perf_redirects), 128'(0));
    check("rst2_perf_stall", 128'(o_perf_stall_cycles), 128'(0));
`endif
    i_resetn = 1'b1;
    tick();
    tick();
    check_head("rst2_b0", 32'h00, 4'hF, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
